// File: rtl/fc_layer_seq.sv
// Sequencer for one fully-connected layer: streams SRAM reads, accumulates MAC-tree psums per neuron,
// applies optional ReLU with saturation and writes each result into the lane-interleaved buffer.
module fc_layer_seq #(
  parameter int LANES   = 64,
  parameter int DW      = 16,
  parameter int ACC_W   = 40,
  parameter int IN_AW   = 4,
  parameter int W_AW    = 12,
  parameter int OUT_AW  = 2,
  parameter int N_W     = 10,
  parameter int MAC_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [IN_AW:0]       cfg_chunks,
  input  logic [N_W-1:0]       cfg_neurons,
  input  logic                 cfg_relu,
  output logic [IN_AW-1:0]     in_addr,
  output logic [W_AW-1:0]      w_addr,
  input  logic signed [DW-1:0] psum,
  output logic [LANES-1:0]     out_we,
  output logic [OUT_AW-1:0]    out_addr,
  output logic [DW-1:0]        out_data,
  output logic                 busy,
  output logic                 done
);

  localparam int PD = MAC_LAT + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t state, state_next;

  logic [IN_AW:0]   chunks_q;
  logic [N_W-1:0]   neurons_q;
  logic             relu_q;
  logic [IN_AW:0]   c_q;
  logic [N_W-1:0]   n_q;
  logic [W_AW-1:0]  w_q;

  logic [PD-1:0]    pv, pf, pl;
  logic [N_W-1:0]   pn [PD];

  logic signed [ACC_W-1:0] acc_q, psum_ext, acc_next, act_val;
  logic [DW-1:0]    sat_val;
  logic [N_W-1:0]   lane_idx;

  logic issue_en, start_ok, cfg_zero, last_chunk, last_neuron, pipe_busy, arrive_last;

  assign start_ok    = (state == S_IDLE) && start && !abort;
  assign cfg_zero    = (cfg_chunks == '0) || (cfg_neurons == '0);
  assign last_chunk  = (c_q == chunks_q - (IN_AW+1)'(1));
  assign last_neuron = (n_q == neurons_q - N_W'(1));
  assign pipe_busy   = |pv;
  assign arrive_last = pv[PD-1] && pl[PD-1];
  assign in_addr     = c_q[IN_AW-1:0];
  assign w_addr      = w_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // The final write is the one that appears once nothing is left in flight.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = cfg_zero ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_chunk && last_neuron) state_next = S_DRAIN;
      S_DRAIN: if ((out_we != '0) && !pipe_busy) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_comb begin
    issue_en = (state == S_ISSUE);
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chunks_q  <= '0;
      neurons_q <= '0;
      relu_q    <= 1'b0;
      c_q       <= '0;
      n_q       <= '0;
      w_q       <= '0;
    end else if (start_ok) begin
      chunks_q  <= cfg_chunks;
      neurons_q <= cfg_neurons;
      relu_q    <= cfg_relu;
      c_q       <= '0;
      n_q       <= '0;
      w_q       <= '0;
    end else if (abort) begin
      c_q <= '0;
      n_q <= '0;
      w_q <= '0;
    end else if (issue_en) begin
      w_q <= w_q + W_AW'(1);
      if (last_chunk) begin
        c_q <= '0;
        n_q <= n_q + N_W'(1);
      end else begin
        c_q <= c_q + (IN_AW+1)'(1);
      end
    end
  end

  // Tags ride alongside the MAC tree latency so each psum knows its neuron and position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      pf <= '0;
      pl <= '0;
      for (int k = 0; k < PD; k++) pn[k] <= '0;
    end else begin
      pv[0] <= issue_en && !abort;
      pf[0] <= (c_q == '0);
      pl[0] <= last_chunk;
      pn[0] <= n_q;
      for (int k = 1; k < PD; k++) begin
        pv[k] <= pv[k-1] && !abort;
        pf[k] <= pf[k-1];
        pl[k] <= pl[k-1];
        pn[k] <= pn[k-1];
      end
    end
  end

  always_comb begin
    psum_ext = {{(ACC_W-DW){psum[DW-1]}}, psum};
    acc_next = pf[PD-1] ? psum_ext : acc_q + psum_ext;
    act_val  = (relu_q && (acc_next < 0)) ? '0 : acc_next;
    if (act_val > SAT_MAX)      sat_val = OUT_MAX;
    else if (act_val < SAT_MIN) sat_val = OUT_MIN;
    else                        sat_val = act_val[DW-1:0];
    lane_idx = pn[PD-1] % N_W'(LANES);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      out_we   <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      if (pv[PD-1]) acc_q <= acc_next;
      out_we <= '0;
      if (arrive_last && !abort) begin
        out_we   <= LANES'(1) << lane_idx;
        out_addr <= OUT_AW'(pn[PD-1] / N_W'(LANES));
        out_data <= sat_val;
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq: a table-driven MAC model feeds psum from delayed w_addr,
// and every write and done pulse is logged for comparison with hand-computed results.
module tb_fc_layer_seq;

  localparam int LANES = 64, DW = 16, IN_AW = 4, W_AW = 12, OUT_AW = 2, N_W = 10, MAC_LAT = 2;

  logic clk = 1'b0;
  logic rst, start, abort, cfg_relu;
  logic [IN_AW:0] cfg_chunks;
  logic [N_W-1:0] cfg_neurons;
  logic [IN_AW-1:0] in_addr;
  logic [W_AW-1:0] w_addr;
  logic signed [DW-1:0] psum;
  logic [LANES-1:0] out_we;
  logic [OUT_AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;

  logic signed [DW-1:0] psum_tab [0:4095];
  logic [W_AW-1:0] hist [0:MAC_LAT+1];
  logic [LANES-1:0] wr_we [$];
  logic [OUT_AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int wr_cyc [$];
  int done_cyc [$];

  fc_layer_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_chunks(cfg_chunks), .cfg_neurons(cfg_neurons), .cfg_relu(cfg_relu),
    .in_addr(in_addr), .w_addr(w_addr), .psum(psum),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC model: the psum for an issue appears 1+MAC_LAT cycles after its address.
  always @(negedge clk) begin
    if (out_we != '0) begin
      wr_we.push_back(out_we);
      wr_addr.push_back(out_addr);
      wr_data.push_back(out_data);
      wr_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (busy) busy_cnt++;
    for (int k = MAC_LAT + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = w_addr;
    psum = psum_tab[hist[MAC_LAT+1]];
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_we.delete();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
    busy_cnt = 0;
  endtask

  task automatic wait_done(input string tag);
    bit got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got = 1;
        break;
      end
    end
    check_output({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic apply_stimulus(input int chunks, input int neurons, input int relu, output int s);
    @(negedge clk);
    clear_log();
    cfg_chunks  = (IN_AW+1)'(chunks);
    cfg_neurons = N_W'(neurons);
    cfg_relu    = relu[0];
    start       = 1'b1;
    s           = cyc;
  endtask

  task automatic run_layer(input string tag, input int chunks, input int neurons, input int relu,
                           output int s);
    apply_stimulus(chunks, neurons, relu, s);
    wait_done(tag);
    repeat (2) @(negedge clk);
  endtask

  task automatic ramp_table();
    for (int i = 0; i < 4096; i++) psum_tab[i] = DW'(i);
  endtask

  initial begin
    int s;
    int bad;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_chunks = '0; cfg_neurons = '0; cfg_relu = 1'b0;
    for (int i = 0; i < 4096; i++) psum_tab[i] = '0;
    for (int k = 0; k <= MAC_LAT + 1; k++) hist[k] = '0;

    repeat (3) @(negedge clk);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_we", 64'(out_we), 64'd0);
    check_output("rst_addrs", 64'({in_addr, w_addr, out_addr}), 64'd0);
    check_output("rst_data", 64'(out_data), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ReLU on single-chunk neurons, back-to-back writes
    psum_tab[0] = 16'sd5; psum_tab[1] = -16'sd7; psum_tab[2] = 16'sd3;
    run_layer("t1", 1, 3, 1, s);
    check_output("t1_nwrites", 64'(wr_we.size()), 64'd3);
    if (wr_we.size() == 3) begin
      check_output("t1_we0", 64'(wr_we[0]), 64'h1);
      check_output("t1_we1", 64'(wr_we[1]), 64'h2);
      check_output("t1_we2", 64'(wr_we[2]), 64'h4);
      check_output("t1_data0", 64'(wr_data[0]), 64'd5);
      check_output("t1_data1", 64'(wr_data[1]), 64'd0);
      check_output("t1_data2", 64'(wr_data[2]), 64'd3);
      check_output("t1_addr", 64'(wr_addr[0] | wr_addr[1] | wr_addr[2]), 64'd0);
      check_output("t1_lat", 64'(wr_cyc[0] - s), 64'd5);
      check_output("t1_spacing", 64'(wr_cyc[2] - wr_cyc[0]), 64'd2);
      check_output("t1_done_cyc", 64'(done_cyc[0]), 64'(wr_cyc[2] + 1));
    end
    check_output("t1_ndone", 64'(done_cyc.size()), 64'd1);

    // Saturation both ways
    for (int i = 0; i < 4; i++) psum_tab[i] = 16'sh7000;
    run_layer("t2a", 4, 1, 0, s);
    check_output("t2a_nwrites", 64'(wr_we.size()), 64'd1);
    check_output("t2a_data", 64'(wr_data[0]), 64'h7FFF);
    check_output("t2a_we", 64'(wr_we[0]), 64'h1);
    for (int i = 0; i < 4; i++) psum_tab[i] = -16'sh7000;
    run_layer("t2b", 4, 1, 0, s);
    check_output("t2b_nwrites", 64'(wr_we.size()), 64'd1);
    check_output("t2b_data", 64'(wr_data[0]), 64'h8000);

    // LANES+1 neurons: wrap of lane, address increment, contiguous weights
    ramp_table();
    run_layer("t3", 2, 65, 0, s);
    check_output("t3_nwrites", 64'(wr_we.size()), 64'd65);
    bad = 0;
    for (int i = 0; i < wr_we.size(); i++) begin
      if (wr_data[i] != DW'(4 * i + 1)) bad++;
      if (wr_we[i] != (64'd1 << (i % 64))) bad++;
      if (wr_addr[i] != OUT_AW'(i / 64)) bad++;
    end
    check_output("t3_trace_bad", 64'(bad), 64'd0);
    if (wr_we.size() == 65) begin
      check_output("t3_n64_we", 64'(wr_we[64]), 64'h1);
      check_output("t3_n64_addr", 64'(wr_addr[64]), 64'd1);
      check_output("t3_n64_data", 64'(wr_data[64]), 64'd257);
    end

    // Zero neurons
    run_layer("t4", 2, 0, 0, s);
    check_output("t4_done_cyc", 64'(done_cyc[0] - s), 64'd1);
    check_output("t4_nwrites", 64'(wr_we.size()), 64'd0);
    check_output("t4_busy_cnt", 64'(busy_cnt), 64'd1);

    // Reset in the middle of ISSUE, then an uninterrupted rerun
    apply_stimulus(2, 3, 0, s);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check_output("t5_busy_pre", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check_output("t5_rst_outs", 64'({in_addr, w_addr, out_addr, out_data, busy, done}), 64'd0);
    check_output("t5_rst_we", 64'(out_we), 64'd0);
    @(negedge clk); rst = 1'b1;
    run_layer("t5", 2, 3, 0, s);
    check_output("t5_nwrites", 64'(wr_we.size()), 64'd3);
    if (wr_we.size() == 3) begin
      check_output("t5_data", 64'({wr_data[0], wr_data[1], wr_data[2]}), {16'd0, 16'd1, 16'd5, 16'd9});
      check_output("t5_we2", 64'(wr_we[2]), 64'h4);
      check_output("t5_lat", 64'(wr_cyc[0] - s), 64'd6);
    end
    check_output("t5_ndone", 64'(done_cyc.size()), 64'd1);

    // A second start during ISSUE is ignored, cfg stays latched
    apply_stimulus(3, 2, 0, s);
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; cfg_neurons = N_W'(5); cfg_chunks = (IN_AW+1)'(1);
    wait_done("t6");
    repeat (2) @(negedge clk);
    check_output("t6_nwrites", 64'(wr_we.size()), 64'd2);
    check_output("t6_data0", 64'(wr_data[0]), 64'd3);
    check_output("t6_data1", 64'(wr_data[1]), 64'd12);

    // Abort in DRAIN drops the pending writes and suppresses done
    apply_stimulus(1, 2, 0, s);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("t7_busy_drain", 64'(busy), 64'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_output("t7_busy_after", 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    check_output("t7_nwrites", 64'(wr_we.size()), 64'd0);
    check_output("t7_ndone", 64'(done_cyc.size()), 64'd0);

    // abort wins over a simultaneous start
    @(negedge clk);
    cfg_chunks = (IN_AW+1)'(1); cfg_neurons = N_W'(1);
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check_output("t8_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
